pagerank_scatter_div: RTL

//  Parametrised scatter stage for one graph partition: per source, computes contrib = rank[src] / out_degree[src]
//  via an internal sequential divider and streams one (dest_id, contrib) pair per edge.

---
 rtl/pagerank_scatter_div_if.sv | 25 ++
 rtl/pagerank_scatter_div.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pagerank_scatter_div_if.sv
// Contribution stream from the scatter stage to the gather queue.
// Valid/ready handshake carrying one (destination, contribution) pair per transfer.
interface pagerank_scatter_div_if #(
  parameter int unsigned ID_W   = 32,
  parameter int unsigned RANK_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [RANK_W-1:0] out_value;
  logic [ID_W-1:0]   out_node_id;

  modport master (
    output out_valid,
    output out_value,
    output out_node_id,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_value,
    input  out_node_id,
    output out_ready
  );
endinterface

// File: rtl/pagerank_scatter_div.sv
// PageRank scatter stage: for each source, contrib = rank / out_degree (restoring divider),
// then stream one (dest_id, contrib) pair per edge over a valid/ready interface.
module pagerank_scatter_div #(
  parameter int unsigned NODES_IN_PARTITION = 4,
  parameter int unsigned MAX_OUT_DEGREE     = 20,
  parameter int unsigned NODES_IN_GRAPH     = 32,
  parameter int unsigned ID_W               = 32,
  parameter int unsigned RANK_W             = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ID_W-1:0]      source_id  [NODES_IN_PARTITION],
  input  logic [ID_W-1:0]      out_degree [NODES_IN_PARTITION],
  input  logic [ID_W-1:0]      dest_id    [NODES_IN_PARTITION][MAX_OUT_DEGREE],
  input  logic [RANK_W-1:0]    rank_in    [NODES_IN_GRAPH],
  pagerank_scatter_div_if.master out_if,
  output logic                 busy,
  output logic                 done,
  output logic [ID_W-1:0]      edges_emitted,
  output logic                 degree_clipped
);

  localparam int unsigned IW = (NODES_IN_PARTITION > 1) ? $clog2(NODES_IN_PARTITION) : 1;
  localparam int unsigned JW = (MAX_OUT_DEGREE > 1) ? $clog2(MAX_OUT_DEGREE) : 1;
  localparam int unsigned GW = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
  localparam int unsigned CW = (RANK_W > 1) ? $clog2(RANK_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIVIDE,
    S_EMIT,
    S_NEXT,
    S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [IW:0]       i_q, i_d;
  logic [JW-1:0]     j_q, j_d;
  logic [ID_W-1:0]   d_q, d_d;
  logic [ID_W-1:0]   rem_q, rem_d;
  logic [RANK_W-1:0] dq_q, dq_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [RANK_W-1:0] out_value_q, out_value_d;
  logic [ID_W-1:0]   out_node_id_q, out_node_id_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ID_W-1:0]   edges_q, edges_d;
  logic              clipped_q, clipped_d;

  logic [IW-1:0]     i_idx;
  logic [ID_W-1:0]   src;
  logic [ID_W-1:0]   deg;
  logic [RANK_W-1:0] rank_sel;
  logic [ID_W:0]     sh;
  logic [ID_W-1:0]   sh_sub;
  logic              ge;
  logic [RANK_W-1:0] quot_nxt;
  logic [JW-1:0]     j_nxt;
  logic              transfer;
  logic              last_edge;

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    d_d           = d_q;
    rem_d         = rem_q;
    dq_d          = dq_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    out_value_d   = out_value_q;
    out_node_id_d = out_node_id_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    edges_d       = edges_q;
    clipped_d     = clipped_q;

    i_idx    = i_q[IW-1:0];
    src      = source_id[i_idx];
    deg      = out_degree[i_idx];
    // Sources outside the graph contribute rank 0 but still emit their edges.
    rank_sel = (src < ID_W'(NODES_IN_GRAPH)) ? rank_in[src[GW-1:0]] : '0;

    // Remainder stays below d, so the low ID_W bits of the subtraction are exact.
    sh       = {rem_q, dq_q[RANK_W-1]};
    ge       = (sh >= {1'b0, d_q});
    sh_sub   = sh[ID_W-1:0] - d_q;
    quot_nxt = {dq_q[RANK_W-2:0], ge};

    j_nxt     = j_q + JW'(1);
    transfer  = out_valid_q && out_if.out_ready;
    last_edge = ((ID_W'(j_q) + ID_W'(1)) == d_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          i_d       = '0;
          j_d       = '0;
          edges_d   = '0;
          clipped_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_LOAD: begin
        if (i_q == (IW+1)'(NODES_IN_PARTITION)) begin
          state_d = S_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          if (deg > ID_W'(MAX_OUT_DEGREE)) begin
            clipped_d = 1'b1;
            d_d       = ID_W'(MAX_OUT_DEGREE);
          end else begin
            d_d = deg;
          end
          dq_d    = rank_sel;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (deg == '0) ? S_NEXT : S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        rem_d = ge ? sh_sub : sh[ID_W-1:0];
        dq_d  = quot_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(RANK_W - 1)) begin
          state_d       = S_EMIT;
          j_d           = '0;
          out_valid_d   = 1'b1;
          out_value_d   = quot_nxt;
          out_node_id_d = dest_id[i_idx][0];
        end
      end
      S_EMIT: begin
        if (transfer) begin
          if (edges_q != '1) begin
            edges_d = edges_q + ID_W'(1);
          end
          if (last_edge) begin
            out_valid_d = 1'b0;
            state_d     = S_NEXT;
          end else begin
            j_d           = j_nxt;
            out_node_id_d = dest_id[i_idx][j_nxt];
          end
        end
      end
      S_NEXT: begin
        i_d     = i_q + (IW+1)'(1);
        j_d     = '0;
        state_d = S_LOAD;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      i_q           <= '0;
      j_q           <= '0;
      d_q           <= '0;
      rem_q         <= '0;
      dq_q          <= '0;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_value_q   <= '0;
      out_node_id_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      edges_q       <= '0;
      clipped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      d_q           <= d_d;
      rem_q         <= rem_d;
      dq_q          <= dq_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_value_q   <= out_value_d;
      out_node_id_q <= out_node_id_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      edges_q       <= edges_d;
      clipped_q     <= clipped_d;
    end
  end

  assign out_if.out_valid   = out_valid_q;
  assign out_if.out_value   = out_value_q;
  assign out_if.out_node_id = out_node_id_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign edges_emitted      = edges_q;
  assign degree_clipped     = clipped_q;

endmodule
